// File: rtl/axi_read_burst_ctrl_pkg.sv
// Shared definitions for the DDR FIFO AXI read/write burst controllers.
// Holds the burst geometry defaults, the clog2 helper, RRESP codes and FSM states.
package axi_read_burst_ctrl_pkg;

  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int burst_bytes(input int data_w, input int len);
    return len * data_w / 8;
  endfunction

  localparam int ADDR_WIDTH_DFLT      = 30;
  localparam int DATA_WIDTH_DFLT      = 128;
  localparam int BURST_LEN_DFLT       = 16;
  localparam int DDR_BURST_DEPTH_DFLT = 1024;
  localparam int BURST_BYTES_DFLT     =
    burst_bytes(DATA_WIDTH_DFLT, BURST_LEN_DFLT);

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_burst_avail_counter.sv
// Up/down count of whole bursts held in the DDR ring, with full and
// sticky overflow flags. Ports: clk, rst (sync, high), inc, dec -> count, full, overflow.
module axi_burst_avail_counter
  import axi_read_burst_ctrl_pkg::*;
#(
  parameter int DEPTH = DDR_BURST_DEPTH_DFLT,
  localparam int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign full     = (cnt_q == FULL_VAL);
  assign count    = cnt_q;
  assign overflow = ovf_q;

  // dec is only raised by a claim, which needs count > 0,
  // so the down path cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case ({inc, dec})
      2'b10: begin
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/axi_read_burst_ctrl.sv
// AXI4 read master draining the DDR burst ring into the output FIFO, one
// burst outstanding at a time. Ports: write-side handshake (wr_burst_done,
// ddr_full/overflow, ddr_bursts_avail), AR/R channels, rd_data/_valid to the
// FIFO, read_resp_error. Optional macro READ_ERR_CHK_EN enables RRESP/RLAST
// checking; without it read_resp_error is tied 0.
module axi_read_burst_ctrl
  import axi_read_burst_ctrl_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = ADDR_WIDTH_DFLT,
  parameter int C_M_AXI_DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int C_M_AXI_BURST_LEN  = BURST_LEN_DFLT,
  parameter int DDR_BURST_DEPTH    = DDR_BURST_DEPTH_DFLT,
  localparam int AVAIL_W = clog2(DDR_BURST_DEPTH) + 1
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          wr_burst_done,
  input  logic                          fifo_room_for_burst,
  output logic [AVAIL_W-1:0]            ddr_bursts_avail,
  output logic                          ddr_full,
  output logic                          ddr_overflow,
  input  logic                          M_AXI_ARREADY,
  output logic                          axi_arvalid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic                          M_AXI_RVALID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic                          M_AXI_RLAST,
  input  logic [1:0]                    M_AXI_RRESP,
  output logic                          axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          rd_data_valid,
  output logic                          read_resp_error
);

  localparam int IDX_W  = clog2(DDR_BURST_DEPTH);
  localparam int BEAT_W = clog2(C_M_AXI_BURST_LEN) + 1;
  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] BURST_BYTES_A =
    AW'(burst_bytes(C_M_AXI_DATA_WIDTH, C_M_AXI_BURST_LEN));

  rd_state_e                    state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic                         arvalid_q, arvalid_d;
  logic [AW-1:0]                araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                         rvalid_q, rvalid_d;

  logic claim, ar_fire, r_fire;

  assign claim   = (state_q == RD_IDLE) &&
                   (ddr_bursts_avail != '0) && fifo_room_for_burst;
  assign ar_fire = arvalid_q && M_AXI_ARREADY;
  assign r_fire  = M_AXI_RVALID && axi_rready;

  assign axi_rready    = (state_q == RD_DATA);
  assign axi_arvalid   = arvalid_q;
  assign axi_araddr    = araddr_q;
  assign rd_data       = rdata_q;
  assign rd_data_valid = rvalid_q;

  axi_burst_avail_counter #(
    .DEPTH(DDR_BURST_DEPTH)
  ) u_avail (
    .clk      (M_AXI_ACLK),
    .rst      (M_AXI_ARESET),
    .inc      (wr_burst_done),
    .dec      (claim),
    .count    (ddr_bursts_avail),
    .full     (ddr_full),
    .overflow (ddr_overflow)
  );

  // Room in the output FIFO is reserved at claim time, so the
  // R beats are forwarded without any backpressure.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    unique case (1'b1)
      (state_q == RD_IDLE): begin
        if (claim) begin
          state_d   = RD_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = AW'(idx_q) * BURST_BYTES_A;
        end
      end
      (state_q == RD_ADDR): begin
        if (ar_fire) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          idx_d     = idx_q + IDX_W'(1);
        end
      end
      (state_q == RD_DATA): begin
        if (r_fire) begin
          rvalid_d = 1'b1;
          rdata_d  = M_AXI_RDATA;
          if (M_AXI_RLAST) begin
            beat_d  = '0;
            state_d = RD_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q   <= RD_IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef READ_ERR_CHK_EN
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M_AXI_BURST_LEN - 1);

  logic err_q, err_d;
  logic unused_rresp0;

  assign unused_rresp0   = M_AXI_RRESP[0];
  assign read_resp_error = err_q;

  // RLAST must coincide exactly with the final expected beat;
  // either mismatch direction flags a length error.
  always_comb begin
    err_d = err_q;
    if (r_fire) begin
      if (M_AXI_RRESP[1]) err_d = 1'b1;
      if (M_AXI_RLAST != (beat_q == LAST_BEAT)) err_d = 1'b1;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) err_q <= 1'b0;
    else              err_q <= err_d;
  end
`else
  logic unused_rresp;

  assign unused_rresp    = ^M_AXI_RRESP;
  assign read_resp_error = 1'b0;
`endif

endmodule

// File: doc/axi_read_burst_ctrl.md
Name: axi_read_burst_ctrl

Overview:
- AXI4 read-side master for the DDR FIFO; the counterpart of the write-address/B-channel controller.
- Tracks how many complete bursts the write side has committed to DDR.
- When bursts are available and the downstream output FIFO can absorb a full burst, it issues one AR burst at a time and accepts the R beats.
- Read data is forwarded to the output FIFO write port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 30, AXI address width.
- C_M_AXI_DATA_WIDTH, 128, AXI data width; burst bytes = C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8.
- C_M_AXI_BURST_LEN, 16, beats per burst (ARLEN = C_M_AXI_BURST_LEN-1).
- DDR_BURST_DEPTH, 1024, DDR ring size in bursts; power of 2; DDR_BURST_DEPTH*burst bytes must be <= 2^C_M_AXI_ADDR_WIDTH.

Ports:
- M_AXI_ACLK  in  1  sole clock
- M_AXI_ARESET  in  1  synchronous, active-high reset
- wr_burst_done  in  1  1-cycle pulse: write side accepted B response for one burst
- fifo_room_for_burst  in  1  output FIFO has >= C_M_AXI_BURST_LEN free entries
- ddr_bursts_avail  out  clog2(DDR_BURST_DEPTH)+1  bursts in DDR not yet claimed by reads
- ddr_full  out  1  ddr_bursts_avail == DDR_BURST_DEPTH; write side must not start a burst
- ddr_overflow  out  1  sticky: wr_burst_done seen while full with no simultaneous claim
- M_AXI_ARREADY  in  1  slave accepts address
- axi_arvalid  out  1  AR valid
- axi_araddr  out  C_M_AXI_ADDR_WIDTH  AR address
- M_AXI_RVALID  in  1  R beat valid
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  R data
- M_AXI_RLAST  in  1  last beat
- M_AXI_RRESP  in  2  R response
- axi_rready  out  1  R ready
- rd_data  out  C_M_AXI_DATA_WIDTH  data to output FIFO
- rd_data_valid  out  1  write enable to output FIFO
- read_resp_error  out  1  sticky R/length error (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, internal burst index 0, beat counter 0.
- Reset mid-operation abandons any burst in flight. The system resets the AXI slave together with this block.
- Availability counter:
  - +1 on wr_burst_done.
  - -1 on the claim (IDLE->ADDR transition).
  - Both in the same cycle: unchanged.
  - wr_burst_done while full and no claim: counter holds, ddr_overflow set.
  - The counter never underflows, because a claim requires avail > 0.
- FSM:
  - IDLE: if ddr_bursts_avail != 0 and fifo_room_for_burst, go to ADDR next cycle. axi_arvalid is registered 1 in that cycle and axi_araddr = burst_idx*burst_bytes. Latency from conditions true to arvalid high is 1 cycle.
  - ADDR: arvalid held until the M_AXI_ARREADY&&axi_arvalid handshake. Address stays stable. On handshake: arvalid 0 next cycle, burst_idx increments (wraps DDR_BURST_DEPTH-1 -> 0), go to DATA.
  - DATA: axi_rready = 1 for the whole state; each RVALID&&RREADY beat increments the beat counter. On the beat with RLAST: beat counter clears, go to IDLE.
- Only one burst outstanding; no AR is issued while in ADDR or DATA.
- rd_data / rd_data_valid: registered copy of the accepted beat, 1-cycle latency, no backpressure. This relies on the reservation by fifo_room_for_burst at claim time.
- fifo_room_for_burst is sampled only in IDLE; its deassertion during DATA is ignored.
- Address arithmetic: burst_idx is clog2(DDR_BURST_DEPTH) bits. The address is zero-extended to C_M_AXI_ADDR_WIDTH; base is 0. The write side uses the same ring and ordering.

Optional Feature:
- READ_ERR_CHK_EN defined:
  - read_resp_error is set on any accepted beat with M_AXI_RRESP[1]=1.
  - It is also set if RLAST arrives when beat count != C_M_AXI_BURST_LEN-1.
  - It is also set if count reaches C_M_AXI_BURST_LEN-1 without RLAST; in that case the FSM still waits for RLAST.
  - Sticky until reset.
- Not defined: read_resp_error tied 0; checking logic absent; FSM identical.

Decomposition:
- Shared package/include: burst-bytes constant, clog2 function, DDR_BURST_DEPTH default, RRESP encodings (OKAY=0, SLVERR=2, DECERR=3). The write-side controller uses the same definitions.
- One natural sub-module, axi_burst_avail_counter: up/down counter with full/overflow flags.

Test Plan:
- Reset then 3 wr_burst_done pulses, fifo_room_for_burst=1, ARREADY=1, 16-beat RLAST bursts -> araddr 0x000, 0x100, 0x200 (128-bit data); 48 rd_data_valid pulses; avail ends at 0.
- wr_burst_done coinciding with the IDLE->ADDR claim cycle -> ddr_bursts_avail unchanged that cycle.
- ARREADY held low 5 cycles -> arvalid stays 1 with stable araddr; deasserts the cycle after handshake; no second AR issued.
- fifo_room_for_burst=0 with avail=2 -> no AR. Raise it -> arvalid 1 cycle later.
- DDR_BURST_DEPTH=4: 4 done pulses -> ddr_full=1. A 5th pulse with no claim -> ddr_overflow=1. Reads run; the 5th address wraps to 0x000.
- READ_ERR_CHK_EN: RRESP=2 on beat 7 -> read_resp_error=1. RLAST on beat 10 -> error=1, FSM returns to IDLE. Without the macro, error stays 0.
